// File: rtl/run_ctrl_pkg.sv
// run_ctrl shared types: FSM state encoding and reset-state helper.
// Imported by the run/resume controller and its interface.
package run_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RS_RUN    = 2'd0,
        RS_HALTED = 2'd1,
        RS_ARMED  = 2'd2,
        RS_RESUME = 2'd3
    } run_state_e;

    function automatic run_state_e reset_state(input bit start_halted);
        return start_halted ? RS_HALTED : RS_RUN;
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Button/CPU-side signal bundle of the run/resume controller.
// master = board + decode side, slave = run_ctrl.
interface run_ctrl_if;
    import run_ctrl_pkg::*;

    logic               BTN_L;
    logic               HALT_INSN;
    logic               STEP_MODE;
    logic               PC_EN;
    logic               HALTED;
    logic               BTN_PRESS;
    logic [STATE_W-1:0] STATE;

    modport master (
        output BTN_L, HALT_INSN, STEP_MODE,
        input  PC_EN, HALTED, BTN_PRESS, STATE
    );

    modport slave (
        input  BTN_L, HALT_INSN, STEP_MODE,
        output PC_EN, HALTED, BTN_PRESS, STATE
    );

endinterface

// File: rtl/run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter,
// and press/release edge detection on the debounced level.
module run_ctrl_btn_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int DB_W      = 5
) (
    input  logic CLK,
    input  logic RST_L,
    input  logic BTN_L,
    output logic BTN_DB_L,
    output logic PRESS,
    output logic RELEASE
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic            db_prev;
    logic [DB_W-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= BTN_L;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has held for DB_CYCLES edges;
    // the counter stops at CNT_MAX because it clears on the flip.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            cnt      <= '0;
            BTN_DB_L <= 1'b1;
        end else if (s2 == BTN_DB_L) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt      <= '0;
            BTN_DB_L <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Previous debounced level for edge detection.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            db_prev <= 1'b1;
        end else begin
            db_prev <= BTN_DB_L;
        end
    end

    assign PRESS   = db_prev & ~BTN_DB_L;
    assign RELEASE = ~db_prev & BTN_DB_L;

endmodule

// File: rtl/run_ctrl.sv
// Run/resume controller: gates PC updates on HALT instructions,
// debounced button presses and single-step mode.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DB_CYCLES    = 16,
    parameter int DB_W         = 5,
    parameter bit START_HALTED = 1'b0
) (
    input logic      CLK,
    input logic      RST_L,
    run_ctrl_if.slave bus
);

    logic       btn_db_l_unused;
    logic       btn_press;
    logic       btn_release;
    run_state_e state;

    run_ctrl_btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db (
        .CLK      (CLK),
        .RST_L    (RST_L),
        .BTN_L    (bus.BTN_L),
        .BTN_DB_L (btn_db_l_unused),
        .PRESS    (btn_press),
        .RELEASE  (btn_release)
    );

    // Halt on HALT/step, arm on press, resume for one cycle on release.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            state <= reset_state(START_HALTED);
        end else begin
            unique case (state)
                RS_RUN: begin
                    if (bus.HALT_INSN || bus.STEP_MODE) begin
                        state <= RS_HALTED;
                    end
                end
                RS_HALTED: begin
                    if (btn_press) begin
                        state <= RS_ARMED;
                    end
                end
                RS_ARMED: begin
                    if (btn_release) begin
                        state <= RS_RESUME;
                    end
                end
                RS_RESUME: begin
                    state <= bus.STEP_MODE ? RS_HALTED : RS_RUN;
                end
            endcase
        end
    end

    // PC enable decode; RESUME always advances exactly once.
    always_comb begin
        bus.PC_EN = 1'b0;
        unique case (state)
            RS_RUN:    bus.PC_EN = ~bus.HALT_INSN & ~bus.STEP_MODE;
            RS_RESUME: bus.PC_EN = 1'b1;
            default:   bus.PC_EN = 1'b0;
        endcase
    end

    assign bus.HALTED    = (state == RS_HALTED) | (state == RS_ARMED);
    assign bus.BTN_PRESS = btn_press;
    assign bus.STATE     = state;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: stimulus predicts each cycle's outputs
// from a behavioural model, a negedge monitor compares them.
module tb_run_ctrl;

    localparam int DB = 4;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;

    always #5 clk = ~clk;

    run_ctrl_if bus ();

    run_ctrl #(
        .DB_CYCLES    (DB),
        .DB_W         (3),
        .START_HALTED (1'b0)
    ) dut (
        .CLK   (clk),
        .RST_L (rst_l),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pc_en;
        logic       halted;
        logic       press;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t mon_a;

    int checks   = 0;
    int errors   = 0;
    int cyc_no   = 0;
    int n_pc_en  = 0;
    int n_press  = 0;
    int n_resume = 0;

    // Reference model: the button seen two cycles late, a level that
    // flips after DB consecutive differing samples, and a 4-mode machine.
    bit m_pipe[$];
    bit m_db;
    bit m_prev;
    int m_run;
    int m_st;

    task automatic m_reset();
        m_pipe = '{1'b1, 1'b1};
        m_db   = 1'b1;
        m_prev = 1'b1;
        m_run  = 0;
        m_st   = 0;
    endtask

    task automatic cyc(input bit rst, input bit btn,
                       input bit halt, input bit step);
        exp_t e;
        bit   prs;
        bit   rel;
        bit   s2;
        @(posedge clk);
        #1;
        rst_l         = !rst;
        bus.BTN_L     = btn;
        bus.HALT_INSN = halt;
        bus.STEP_MODE = step;
        prs = m_prev && !m_db;
        rel = !m_prev && m_db;
        e.st     = 2'(m_st);
        e.halted = (m_st == 1) || (m_st == 2);
        e.press  = prs;
        e.pc_en  = (m_st == 0) ? (!halt && !step) : (m_st == 3);
        sb.push_back(e);
        if (rst) begin
            m_reset();
        end else begin
            s2 = m_pipe.pop_front();
            m_pipe.push_back(btn);
            m_prev = m_db;
            if (s2 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db  = s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            case (m_st)
                0:       if (halt || step) m_st = 1;
                1:       if (prs) m_st = 2;
                2:       if (rel) m_st = 3;
                default: m_st = step ? 1 : 0;
            endcase
        end
    endtask

    task automatic hold(input int n, input bit btn,
                        input bit halt, input bit step);
        repeat (n) cyc(1'b0, btn, halt, step);
    endtask

    task automatic press_release(input bit step);
        hold(8, 1'b0, 1'b0, step);
        hold(12, 1'b1, 1'b0, step);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Monitor: compare every predicted cycle and tally observed events.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            mon_a.pc_en  = bus.PC_EN;
            mon_a.halted = bus.HALTED;
            mon_a.press  = bus.BTN_PRESS;
            mon_a.st     = bus.STATE;
            cyc_no++;
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL cycle %0d: got pc_en=%b halted=%b press=%b state=%0d, expected pc_en=%b halted=%b press=%b state=%0d",
                         cyc_no, mon_a.pc_en, mon_a.halted, mon_a.press, mon_a.st,
                         mon_e.pc_en, mon_e.halted, mon_e.press, mon_e.st);
            end
        end
        if (bus.PC_EN === 1'b1) n_pc_en++;
        if (bus.BTN_PRESS === 1'b1) n_press++;
        if (bus.STATE === 2'd3) n_resume++;
    end

    initial begin
        int base;
        int btn_left;
        bit rbtn;
        bit rstep;

        bus.BTN_L     = 1'b1;
        bus.HALT_INSN = 1'b0;
        bus.STEP_MODE = 1'b0;
        rst_l         = 1'b0;
        repeat (2) @(posedge clk);
        m_reset();

        // Run, then HALT on cycle 10; HALT_INSN ignored while halted.
        hold(9, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        hold(4, 1'b1, 1'b1, 1'b0);
        settle();
        chk("halt_state", int'(bus.STATE), 1);
        chk("halt_flag", int'(bus.HALTED), 1);

        // Long press then release: one press pulse, one RESUME cycle.
        base = n_resume;
        hold(10, 1'b0, 1'b0, 1'b0);
        hold(14, 1'b1, 1'b0, 1'b0);
        settle();
        chk("resume_once", n_resume - base, 1);
        chk("back_to_run", int'(bus.STATE), 0);

        // Bounce shorter than the debounce window while halted.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        settle();
        base = n_press;
        repeat (5) begin
            hold(2, 1'b0, 1'b0, 1'b0);
            hold(2, 1'b1, 1'b0, 1'b0);
        end
        hold(8, 1'b1, 1'b0, 1'b0);
        settle();
        chk("bounce_no_press", n_press - base, 0);
        chk("bounce_halted", int'(bus.STATE), 1);

        // Resume to RUN, then single-step three instructions.
        press_release(1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        base = n_pc_en;
        repeat (3) press_release(1'b1);
        settle();
        chk("step_pulses", n_pc_en - base, 3);
        chk("step_halted", int'(bus.STATE), 1);

        // Leaving step mode while halted applies at the next resume.
        hold(3, 1'b1, 1'b0, 1'b0);
        press_release(1'b0);
        settle();
        chk("step_off_run", int'(bus.STATE), 0);

        // Button already held when HALT arrives.
        hold(10, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        hold(5, 1'b0, 1'b0, 1'b0);
        base = n_resume;
        hold(12, 1'b1, 1'b0, 1'b0);
        settle();
        chk("held_no_resume", n_resume - base, 0);
        chk("held_still_halt", int'(bus.STATE), 1);
        base = n_resume;
        press_release(1'b0);
        settle();
        chk("held_fresh_press", n_resume - base, 1);

        // Reset while ARMED discards the pending press.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        hold(8, 1'b0, 1'b0, 1'b0);
        settle();
        chk("armed_state", int'(bus.STATE), 2);
        base = n_resume;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("rst_state", int'(bus.STATE), 0);
        chk("rst_press", int'(bus.BTN_PRESS), 0);
        hold(4, 1'b0, 1'b0, 1'b0);
        hold(16, 1'b1, 1'b0, 1'b0);
        settle();
        chk("rst_no_resume", n_resume - base, 0);

        // Randomized traffic against the model.
        btn_left = 0;
        rbtn     = 1'b1;
        rstep    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (btn_left == 0) begin
                rbtn     = !rbtn;
                btn_left = int'($urandom_range(1, 12));
            end
            btn_left--;
            if ($urandom_range(0, 199) == 0) rstep = !rstep;
            cyc($urandom_range(0, 499) == 0, rbtn,
                $urandom_range(0, 9) == 0, rstep);
        end
        settle();
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Front-end run/resume controller for the single-cycle CPU.
- Conditions the raw active-low enable push-button: 2-flop synchronizer plus debounce, then press/release edge detection.
- Runs a small state machine that gates the PC update (PC_EN) on decoded HALT instructions and on button presses, with an optional single-step mode.
- Sits between the board button and the PC register; it is the producer of the enable/resume events that the halt logic consumes.

Parameters:
- DB_CYCLES, 16: consecutive stable cycles required before the debounced button level changes.
- DB_W, 5: debounce counter width; must satisfy 2^DB_W > DB_CYCLES.
- START_HALTED, 0: 1 = leave reset in HALTED (waits for a button press); 0 = leave reset in RUN.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_L  in  1  synchronous, active-low reset.
- BTN_L  in  1  raw, asynchronous, bouncy enable push-button; 0 = pressed.
- HALT_INSN  in  1  current instruction decodes as HALT.
- STEP_MODE  in  1  1 = execute one instruction per button press/release.
- PC_EN  out  1  PC may advance this cycle.
- HALTED  out  1  CPU stopped; 1 in HALTED and ARMED.
- BTN_PRESS  out  1  one-cycle pulse on each debounced press.
- STATE  out  2  current FSM state, for debug LEDs.

Behaviour:
- Reset (RST_L=0 at a CLK edge):
  - Sync flops set to 1; debounced level BTN_DB_L set to 1; debounce counter set to 0.
  - State = START_HALTED ? HALTED : RUN.
  - Resulting outputs: BTN_PRESS=0; HALTED, STATE and PC_EN follow the reset state.
- Synchronizer: s1 <= BTN_L; s2 <= s1. Two cycles of latency.
- Debounce:
  - When s2 == BTN_DB_L, counter clears to 0.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1 and s2 still differs, BTN_DB_L <= s2 and the counter clears.
  - Any glitch shorter than DB_CYCLES cycles never changes BTN_DB_L.
- Edge detection (registered previous BTN_DB_L):
  - Press event = previous 1, current 0. BTN_PRESS = press event, combinational from registers, 1 cycle wide.
  - Release event = previous 0, current 1.
- FSM states: RUN=0, HALTED=1, ARMED=2, RESUME=3. All outputs are decoded combinationally from state and inputs.
  - RUN:
    - PC_EN = ~HALT_INSN & ~STEP_MODE.
    - If HALT_INSN or STEP_MODE is 1, next state is HALTED; otherwise stay in RUN.
    - Button events are ignored in RUN.
  - HALTED:
    - PC_EN=0.
    - Press event moves to ARMED. HALT_INSN has no effect.
  - ARMED:
    - PC_EN=0.
    - Release event moves to RESUME. Further press events are impossible until a release occurs; HALT_INSN is ignored.
  - RESUME:
    - PC_EN=1 for exactly one cycle; this advances past the HALT or the stepped instruction.
    - Next state = STEP_MODE ? HALTED : RUN, sampled in this cycle.
- HALTED output = (state==HALTED) | (state==ARMED).
- Boundary conditions:
  - Button already held when HALT is entered: no press event is seen. The button must be released, then a fresh press and release is needed to resume.
  - HALT_INSN in the same cycle as RESUME: RESUME still asserts PC_EN=1. The HALT instruction is re-evaluated in RUN on the next cycle.
  - STEP_MODE deasserted while HALTED: takes effect from the next RESUME.
  - Reset mid-debounce or mid-ARMED: the whole machine returns to its reset values on the next edge, and the pending press is discarded.
  - Debounce counter saturates logically at DB_CYCLES-1 and never wraps.

Decomposition:
- constants.v carries `define names for the four state encodings (RS_RUN, RS_HALTED, RS_ARMED, RS_RESUME) and the state width (2).
- Sub-module btn_debounce (parameters DB_CYCLES, DB_W; ports CLK, RST_L, BTN_L, BTN_DB_L, PRESS, RELEASE) contains the synchronizer, debounce counter and edge detector.
- run_ctrl instantiates btn_debounce and holds only the FSM and output decode.

Test Plan (DB_CYCLES=4 for simulation):
- Reset with START_HALTED=0, then HALT_INSN=1 on cycle 10 -> PC_EN=0 on cycle 10; HALTED=1 and STATE=1 from cycle 11.
- While HALTED, hold BTN_L=0 for 10 cycles then return it to 1 -> BTN_PRESS pulses once ~6 cycles after the fall; STATE=2; after release debounce, exactly one cycle of PC_EN=1 with STATE=3, then STATE=0.
- Bounce: BTN_L toggles every 2 cycles for 20 cycles while HALTED -> BTN_PRESS never asserts; state stays HALTED.
- STEP_MODE=1 from RUN -> HALTED next cycle. Three press/release pairs -> exactly three single-cycle PC_EN pulses, returning to HALTED after each.
- Button held low before HALT_INSN -> no resume while held. After release plus a new press/release -> one PC_EN pulse.
- RST_L=0 for one cycle while in ARMED -> STATE returns to 0 (or 1 if START_HALTED=1), BTN_PRESS=0, and no PC_EN pulse from the aborted press.
